mem_readback: RTL and testbench

Read-side sequencer for the `memory` block. It sweeps a programmable address range over the memory's `raddr`/`dout` read port and streams the words out on a valid/ready interface. Backpressure is absorbed by a small credit-managed FIFO, so the registered, free-running read port is never stalled or mis-sampled. It sits beside `memory` in the reinit test designs and is used to dump contents for comparison against the init file.

---
 rtl/mem_pkg.sv | 26 ++
 rtl/mem_readback_if.sv | 15 +
 rtl/rb_fifo.sv | 59 +++++
 rtl/mem_readback.sv | 153 +++++++++++++++
 tb/tb_mem_readback.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory read-back sequencer.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rb_state_e;

  // Per-beat side information carried through the output buffer with the data.
  typedef struct packed {
    logic [31:0] addr;
    logic        last;
  } rb_meta_t;

  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

  // Wrap an address into a power-of-two memory; upper bits forced to zero.
  function automatic logic [31:0] addr_wrap(input logic [31:0] a, input int unsigned depth);
    return a & (depth - 1);
  endfunction

endpackage

// File: rtl/mem_readback_if.sv
// Output stream of the read-back sequencer: word, source address, last flag.
interface mem_readback_if #(
  parameter int WID = 4
);
  logic [WID-1:0] out_data;
  logic [31:0]    out_addr;
  logic           out_valid;
  logic           out_ready;
  logic           out_last;

  modport master (output out_data, output out_addr, output out_valid, output out_last,
                  input  out_ready);
  modport slave  (input  out_data, input  out_addr, input  out_valid, input  out_last,
                  output out_ready);
endinterface

// File: rtl/rb_fifo.sv
// Small synchronous FIFO holding {addr, last, data} beats; count drives the credit check.
module rb_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          valid,
  output logic [CW-1:0] count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Next-state: write at tail on push, advance head on pop; both may happen at once.
  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) begin
      mem_d[wptr_q] = wdata;
      wptr_d        = nxt(wptr_q);
    end
    if (pop) rptr_d = nxt(rptr_q);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  // Storage is cleared on reset so the head reads zero out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign rdata = mem_q[rptr_q];
  assign valid = (cnt_q != '0);
  assign count = cnt_q;

endmodule

// File: rtl/mem_readback.sv
// Sweeps an address range over a registered memory read port and streams the words
// out through a credit-managed FIFO so the free-running read port never stalls.
module mem_readback
  import mem_pkg::*;
#(
  parameter int WID_MEM    = 4,
  parameter int DEPTH_MEM  = 8192,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [31:0]        first_addr,
  input  logic [31:0]        num_words,
  output logic               busy,
  output logic               done,
  output logic [31:0]        raddr,
  input  logic [WID_MEM-1:0] mem_dout,
  mem_readback_if.master     ob
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int FW = WID_MEM + 33;

  if (!is_pow2(DEPTH_MEM)) begin : g_bad_depth
    $error("DEPTH_MEM must be a power of two");
  end

  rb_state_e state_q, state_d;
  logic [31:0] base_q, base_d, len_q, len_d, idx_q, idx_d, raddr_q, raddr_d;
  logic [31:0] addr1_q, addr1_d;
  logic        tag0_q, tag0_d, last0_q, last0_d;
  logic        tag1_q, tag1_d, last1_q, last1_d;
  logic        busy_q, busy_d, done_q, done_d;

  logic [FW-1:0]      fifo_wdata, fifo_rdata;
  logic [CW-1:0]      fifo_cnt;
  logic               fifo_valid, pop, credit_ok;
  rb_meta_t           head_meta;
  logic [WID_MEM-1:0] head_data;

  // Stage 0 is the read currently on raddr, stage 1 is the word on mem_dout this
  // cycle. Counting both against the FIFO guarantees every tagged word has a slot.
  assign credit_ok = (32'(fifo_cnt) + {31'b0, tag0_q} + {31'b0, tag1_q}) < 32'(FIFO_DEPTH);
  assign pop       = fifo_valid && ob.out_ready;

  // Sequencer next-state, address issue and tag pipeline.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    idx_d   = idx_q;
    raddr_d = raddr_q;
    tag0_d  = 1'b0;
    last0_d = 1'b0;
    tag1_d  = tag0_q;
    last1_d = last0_q;
    addr1_d = raddr_q;
    case (state_q)
      IDLE: if (start) begin
        base_d = first_addr;
        len_d  = num_words;
        if (num_words == 32'd0) begin
          state_d = DONE;
        end else begin
          // First read goes out in the very next cycle; the FIFO is empty here.
          state_d = ISSUE;
          raddr_d = addr_wrap(first_addr, DEPTH_MEM);
          tag0_d  = 1'b1;
          last0_d = (num_words == 32'd1);
          idx_d   = 32'd1;
        end
      end
      ISSUE: begin
        if (idx_q == len_q) begin
          state_d = DRAIN;
        end else if (credit_ok) begin
          raddr_d = addr_wrap(base_q + idx_q, DEPTH_MEM);
          tag0_d  = 1'b1;
          last0_d = (idx_q == len_q - 32'd1);
          idx_d   = idx_q + 32'd1;
        end
      end
      DRAIN: begin
        // The last-flagged beat is the final word, so its pop empties everything.
        if (pop && head_meta.last && fifo_cnt == CW'(1) && !tag0_q && !tag1_q)
          state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_q == DONE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      base_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      raddr_q <= '0;
      addr1_q <= '0;
      tag0_q  <= 1'b0;
      last0_q <= 1'b0;
      tag1_q  <= 1'b0;
      last1_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      raddr_q <= raddr_d;
      addr1_q <= addr1_d;
      tag0_q  <= tag0_d;
      last0_q <= last0_d;
      tag1_q  <= tag1_d;
      last1_q <= last1_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign fifo_wdata = {addr1_q, last1_q, mem_dout};

  rb_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tag1_q),
    .wdata (fifo_wdata),
    .pop   (pop),
    .rdata (fifo_rdata),
    .valid (fifo_valid),
    .count (fifo_cnt)
  );

  assign {head_meta, head_data} = fifo_rdata;

  assign busy         = busy_q;
  assign done         = done_q;
  assign raddr        = raddr_q;
  assign ob.out_valid = fifo_valid;
  assign ob.out_data  = head_data;
  assign ob.out_addr  = head_meta.addr;
  assign ob.out_last  = head_meta.last;

endmodule

// File: tb/tb_mem_readback.sv
// Randomized bench for mem_readback: a memory model plus a queue of expected beats
// built from the address-range rules, with cycle-level timing checks.
module tb_mem_readback;
  localparam int D  = 8192;
  localparam int FD = 4;

  logic        clk, reset, start, busy, done;
  logic [31:0] first_addr, num_words, raddr;
  logic [3:0]  mem_dout;
  logic [3:0]  memarr [D];
  int          n_chk = 0, n_err = 0;

  mem_readback_if #(.WID(4)) ob ();

  mem_readback #(.WID_MEM(4), .DEPTH_MEM(D), .FIFO_DEPTH(FD)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .first_addr (first_addr),
    .num_words  (num_words),
    .busy       (busy),
    .done       (done),
    .raddr      (raddr),
    .mem_dout   (mem_dout),
    .ob         (ob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered memory read port: raddr in cycle N gives dout in cycle N+1.
  always @(posedge clk) mem_dout <= memarr[raddr[12:0]];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_done"},  done, 0);
    chk({tag, "_valid"}, ob.out_valid, 0);
    chk({tag, "_last"},  ob.out_last, 0);
    chk({tag, "_raddr"}, raddr, 0);
    chk({tag, "_data"},  ob.out_data, 0);
    chk({tag, "_addr"},  ob.out_addr, 0);
  endtask

  // One range read. rdy_pct=100 enables exact timing checks. ign_cyc>0 pulses a
  // bogus start in that cycle; abort_beats>0 resets after that many beats.
  task automatic run(input logic [31:0] fa, input logic [31:0] n, input int rdy_pct,
                     input int ign_cyc, input int abort_beats);
    logic [31:0] xa[$];
    logic [3:0]  xd[$];
    logic        xl[$];
    logic [31:0] a, prev_raddr, ea;
    logic [36:0] ph;
    int          cyc, beats, issued, budget, first_v;
    bit          seen_done, stall;

    for (longint k = 0; k < longint'(n); k++) begin
      a = 32'((longint'(fa) + k) % D);
      xa.push_back(a);
      xd.push_back(memarr[a[12:0]]);
      xl.push_back(k == longint'(n) - 1);
    end

    @(posedge clk); #1;
    start = 1'b1; first_addr = fa; num_words = n;
    ob.out_ready = ($urandom_range(99) < rdy_pct);
    cyc = 0; beats = 0; issued = 0; first_v = -1; seen_done = 0; stall = 0;
    budget = 8 * int'(n) + 40;
    ph = '0; prev_raddr = '0;

    while (!seen_done && cyc < budget) begin
      @(negedge clk);
      if (cyc == 1) begin
        chk("busy_c1", busy, 1);
        if (n != 0) begin
          chk("raddr_c1", raddr, fa % D);
          issued = 1;
        end
      end else if (cyc > 1 && n != 0 && raddr != prev_raddr) begin
        issued++;
        ea = 32'((longint'(fa) + longint'(issued - 1)) % D);
        chk("raddr_seq", raddr, ea);
        chk("credit", ((issued - beats) <= FD) && (longint'(issued) <= longint'(n)), 1);
      end
      if (stall) begin
        chk("stall_valid", ob.out_valid, 1);
        chk("stall_hold", {ob.out_addr, ob.out_data, ob.out_last}, ph);
      end
      if (n == 0) chk("zero_valid", ob.out_valid, 0);
      if (ob.out_valid && first_v < 0) begin
        first_v = cyc;
        if (rdy_pct >= 100) chk("first_valid_cyc", cyc, 3);
      end
      if (ob.out_valid && ob.out_ready) begin
        if (xa.size() == 0) chk("extra_beat", 1, 0);
        else chk("beat", {ob.out_addr, ob.out_data, ob.out_last},
                 {xa.pop_front(), xd.pop_front(), xl.pop_front()});
        beats++;
      end
      stall = ob.out_valid && !ob.out_ready;
      ph = {ob.out_addr, ob.out_data, ob.out_last};
      if (done) begin
        seen_done = 1;
        chk("done_all_beats", xa.size(), 0);
        chk("done_busy", busy, 0);
        if (abort_beats > 0) chk("abort_done", 1, 0);
        if (rdy_pct >= 100) chk("done_cyc", cyc, (n == 0) ? 2 : int'(n) + 4);
      end
      prev_raddr = raddr;

      if (abort_beats > 0 && beats == abort_beats) begin
        @(posedge clk); #1;
        start = 1'b0; reset = 1'b0;
        #1;
        chk_reset_vals("abort");
        repeat (4) begin
          @(negedge clk);
          chk("abort_quiet", {busy, done, ob.out_valid}, 0);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        return;
      end

      @(posedge clk); #1;
      start = 1'b0;
      if (cyc + 1 == ign_cyc) begin
        start = 1'b1; first_addr = fa + 32'd100; num_words = 32'd3;
      end
      ob.out_ready = ($urandom_range(99) < rdy_pct);
      cyc++;
    end
    start = 1'b0;
    if (!seen_done) chk("timeout", 0, 1);
  endtask

  initial begin
    for (int i = 0; i < D; i++) memarr[i] = i[3:0];
    reset = 1'b0; start = 1'b0; first_addr = '0; num_words = '0; ob.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("reset");
    @(posedge clk); #1;
    reset = 1'b1;

    run(32'd10, 32'd5, 100, -1, 0);        // basic range
    run(32'd8190, 32'd4, 100, -1, 0);      // wrap
    run(32'd77, 32'd0, 100, -1, 0);        // zero length

    for (int i = 0; i < D; i++) memarr[i] = 4'($urandom);
    run($urandom_range(D - 1), 32'd64, 50, -1, 0);       // backpressure
    run($urandom_range(D - 1), 32'd12, 100, 4, 0);       // ignored start
    run(32'd3, 32'd20, 100, -1, 3);                      // reset mid-stream
    run(32'd10, 32'd5, 100, -1, 0);                      // restart after reset
    for (int r = 0; r < 4; r++)
      run($urandom_range(D - 1), $urandom_range(1, 40), $urandom_range(30, 100), -1, 0);
    run(32'd8000, 32'd8200, 100, -1, 0);                 // longer than memory

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
